if_stage: RTL and testbench

Instruction-fetch stage feeding the decode stage. Owns the program counter and drives a single-outstanding request/ready handshake to instruction memory. Presents one instruction and its address per cycle to decode and holds them under stall. Accepts control-flow redirects (jump, jump-register, taken branch) resolved in decode, squashes wrong-path fetches, and freezes permanently on halt.

---
 rtl/if_stage.sv | 200 ++++++++++++++++++++
 tb/tb_if_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding decode.
//
// Owns the program counter and drives a single-outstanding request/ready
// handshake to instruction memory. Presents one instruction and its
// address per cycle to decode, holds them while decode stalls, applies
// control-flow redirects resolved in decode, and freezes on halt.
//
// Handshake: imem_req stays high with imem_addr stable until imem_ready
// pulses for one cycle; imem_rdata is valid in that cycle. Ready may
// arrive in the same cycle the request is first raised (zero wait).
// Decode consumes inst/inst_addr_out/inst_valid in every cycle where
// pc_enable=1 and stall=0.
//
// Ports:
//   clk, rst_b            clock, synchronous active-high reset
//   pc_enable, stall      advance = pc_enable & ~stall
//   halted                halt request (sticky once taken, until reset)
//   jump, jump_register,
//   branch_taken          redirect kind resolved in decode
//   jea, imm_extend,
//   rs_data, id_inst_addr target operands from decode
//   imem_req, imem_addr   fetch request/address
//   imem_ready, imem_rdata fetch response
//   inst, inst_addr_out,
//   inst_valid            instruction presented to decode (inst=0 is bubble)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        pc_enable,
  input  logic        stall,
  input  logic        halted,
  input  logic        jump,
  input  logic        jump_register,
  input  logic        branch_taken,
  input  logic [25:0] jea,
  input  logic [31:0] imm_extend,
  input  logic [31:0] rs_data,
  input  logic [31:0] id_inst_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_addr_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        inst_valid_q, inst_valid_d;

  logic        advance;
  logic        redir;
  logic [31:0] p4;
  logic [31:0] target;
  logic [31:0] pc_inc;

  always_comb begin
    advance = pc_enable & ~stall;
    redir   = (jump | jump_register | branch_taken) & advance;
    p4      = id_inst_addr + 32'd4;
    pc_inc  = pc_q + 32'd4;  // 32'hFFFF_FFFC wraps to 0
    if (jump_register)
      target = rs_data;
    else if (jump)
      target = {p4[31:28], jea, 2'b00};
    else
      target = p4 + {imm_extend[29:0], 2'b00};
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    squash_d     = squash_q;
    pend_pc_d    = pend_pc_q;
    buf_d        = buf_q;
    buf_addr_d   = buf_addr_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;

    // Decode consumed the current output; unless a word is delivered
    // below, it sees a bubble next cycle. Address is left as-is.
    if (advance) begin
      inst_d       = 32'd0;
      inst_valid_d = 1'b0;
    end

    case (state_q)
      S_RUN: begin
        if (halted) begin
          if (imem_ready) begin
            state_d      = S_HALT;
            inst_d       = 32'd0;
            inst_valid_d = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imem_ready) begin
          if (squash_q || redir) begin
            // Wrong-path word: drop it. A redirect arriving now is newer
            // than any pending target, so it wins.
            squash_d = 1'b0;
            pc_d     = redir ? target : pend_pc_q;
          end else if (advance) begin
            inst_d       = imem_rdata;
            inst_addr_d  = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_inc;
          end else begin
            buf_d      = imem_rdata;
            buf_addr_d = pc_q;
            pc_d       = pc_inc;
            state_d    = S_FULL;
          end
        end else if (redir) begin
          // Address must stay stable until ready; remember where to go.
          squash_d  = 1'b1;
          pend_pc_d = target;
        end
      end

      S_FULL: begin
        if (halted) begin
          state_d      = S_HALT;
          inst_d       = 32'd0;
          inst_valid_d = 1'b0;
        end else if (redir) begin
          // Buffered word is the sequential successor: wrong path.
          pc_d    = target;
          state_d = S_RUN;
        end else if (advance) begin
          inst_d       = buf_q;
          inst_addr_d  = buf_addr_q;
          inst_valid_d = 1'b1;
          state_d      = S_RUN;
        end
      end

      S_DRAIN: begin
        if (imem_ready) begin
          state_d      = S_HALT;
          inst_d       = 32'd0;
          inst_valid_d = 1'b0;
        end
      end

      default: begin  // S_HALT: frozen until reset
        inst_d       = 32'd0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      squash_q     <= 1'b0;
      pend_pc_q    <= 32'd0;
      buf_q        <= 32'd0;
      buf_addr_q   <= 32'd0;
      inst_q       <= 32'd0;
      inst_addr_q  <= 32'd0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      squash_q     <= squash_d;
      pend_pc_q    <= pend_pc_d;
      buf_q        <= buf_d;
      buf_addr_q   <= buf_addr_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem_req      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign imem_addr     = pc_q;
  assign inst          = inst_q;
  assign inst_addr_out = inst_addr_q;
  assign inst_valid    = inst_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: memory responder with configurable wait,
// directed decode-side stimulus, and a scoreboard of expected
// {inst, addr} pairs consumed by a monitor whenever decode accepts.
module tb_if_stage;

  localparam int W = 64;

  logic        clk;
  logic        rst_b;
  logic        pc_enable;
  logic        stall;
  logic        halted;
  logic        jump;
  logic        jump_register;
  logic        branch_taken;
  logic [25:0] jea;
  logic [31:0] imm_extend;
  logic [31:0] rs_data;
  logic [31:0] id_inst_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr_out;
  logic        inst_valid;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;

  // memory model controls
  int  wait_cfg;
  int  mem_cnt;
  logic force_ready;

  if_stage dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .pc_enable     (pc_enable),
    .stall         (stall),
    .halted        (halted),
    .jump          (jump),
    .jump_register (jump_register),
    .branch_taken  (branch_taken),
    .jea           (jea),
    .imm_extend    (imm_extend),
    .rs_data       (rs_data),
    .id_inst_addr  (id_inst_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_addr_out (inst_addr_out),
    .inst_valid    (inst_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  // ready after wait_cfg non-ready cycles of an outstanding request;
  // word contents are a fixed function of the address.
  always @(posedge clk) begin
    if (rst_b || !imem_req || imem_ready) mem_cnt <= 0;
    else                                   mem_cnt <= mem_cnt + 1;
  end
  assign imem_ready = (imem_req && (mem_cnt >= wait_cfg)) || force_ready;
  assign imem_rdata = imem_addr + 32'h1000_0001;

  function automatic logic [W-1:0] exp_word(input logic [31:0] addr);
    return {addr + 32'h1000_0001, addr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int wcfg);
    rst_b         = 1'b1;
    pc_enable     = 1'b0;
    stall         = 1'b0;
    halted        = 1'b0;
    jump          = 1'b0;
    jump_register = 1'b0;
    branch_taken  = 1'b0;
    jea           = 26'd0;
    imm_extend    = 32'd0;
    rs_data       = 32'd0;
    id_inst_addr  = 32'd0;
    force_ready   = 1'b0;
    wait_cfg      = wcfg;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_drain(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_b && inst_valid && pc_enable && !stall) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_inst: got addr %h inst %h, expected none", inst_addr_out, inst);
      end else begin
        e = exp_q.pop_front();
        if ({inst, inst_addr_out} !== e) begin
          n_errors++;
          $display("FAIL sb_inst: got addr %h inst %h expected addr %h inst %h",
                   inst_addr_out, inst, e[31:0], e[63:32]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    wait_cfg = 0;
    force_ready = 1'b0;
    do_reset(0);
    rst_b = 1'b1;
    step();

    // A: zero-wait sequential fetch
    do_reset(0);
    pc_enable = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_word(32'(4 * i)));
    @(negedge clk);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_addr", inst_addr_out, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd1);
    chk("rst_imem_addr", imem_addr, 32'd0);
    step();
    @(negedge clk);
    chk("seq_valid_c2", {31'd0, inst_valid}, 32'd1);
    repeat (8) step();
    pc_enable = 1'b0;
    chk_drain("seq_drain");

    // B: taken branch, one bubble
    do_reset(0);
    pc_enable = 1'b1;
    exp_q.push_back(exp_word(32'h0));
    exp_q.push_back(exp_word(32'h4));
    exp_q.push_back(exp_word(32'h84));
    exp_q.push_back(exp_word(32'h88));
    step();
    step();
    branch_taken = 1'b1;
    id_inst_addr = 32'h40;
    imm_extend   = 32'h10;
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br_bubble_inst", inst, 32'd0);
    chk("br_bubble_valid", {31'd0, inst_valid}, 32'd0);
    chk("br_target_addr", imem_addr, 32'h84);
    repeat (3) step();
    pc_enable = 1'b0;
    chk_drain("br_drain");

    // C: JR while a 3-cycle-wait request to 0x10 is outstanding
    do_reset(0);
    pc_enable     = 1'b1;
    jump_register = 1'b1;
    rs_data       = 32'h10;
    exp_q.push_back(exp_word(32'h200));
    exp_q.push_back(exp_word(32'h204));
    step();
    rs_data  = 32'h200;
    wait_cfg = 3;
    @(negedge clk);
    chk("jr_addr_c2", imem_addr, 32'h10);
    chk("jr_req_c2", {31'd0, imem_req}, 32'd1);
    step();
    jump_register = 1'b0;
    @(negedge clk);
    chk("jr_addr_c3", imem_addr, 32'h10);
    chk("jr_valid_c3", {31'd0, inst_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("jr_addr_c4", imem_addr, 32'h10);
    step();
    @(negedge clk);
    chk("jr_addr_c5", imem_addr, 32'h10);
    step();
    wait_cfg = 0;
    @(negedge clk);
    chk("jr_target_addr", imem_addr, 32'h200);
    chk("jr_squashed_valid", {31'd0, inst_valid}, 32'd0);
    repeat (3) step();
    pc_enable = 1'b0;
    chk_drain("jr_drain");

    // D: stall when ready arrives -> FULL
    do_reset(0);
    pc_enable = 1'b1;
    exp_q.push_back(exp_word(32'h0));
    exp_q.push_back(exp_word(32'h4));
    exp_q.push_back(exp_word(32'h8));
    exp_q.push_back(exp_word(32'hC));
    step();
    step();
    stall = 1'b1;
    @(negedge clk);
    chk("stall_req_c3", {31'd0, imem_req}, 32'd1);
    chk("stall_addr_c3", inst_addr_out, 32'h4);
    step();
    @(negedge clk);
    chk("full_req_c4", {31'd0, imem_req}, 32'd0);
    chk("full_hold_addr", inst_addr_out, 32'h4);
    chk("full_hold_valid", {31'd0, inst_valid}, 32'd1);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("full_req_c5", {31'd0, imem_req}, 32'd0);
    step();
    @(negedge clk);
    chk("resume_addr", imem_addr, 32'hC);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    repeat (2) step();
    pc_enable = 1'b0;
    chk_drain("stall_drain");

    // E: jump target formation
    do_reset(0);
    pc_enable = 1'b1;
    exp_q.push_back(exp_word(32'h0));
    exp_q.push_back(exp_word(32'hF000_0400));
    step();
    jump         = 1'b1;
    id_inst_addr = 32'hF000_0010;
    jea          = 26'h0000100;
    step();
    jump = 1'b0;
    @(negedge clk);
    chk("j_target_addr", imem_addr, 32'hF000_0400);
    chk("j_bubble_valid", {31'd0, inst_valid}, 32'd0);
    repeat (2) step();
    pc_enable = 1'b0;
    chk_drain("j_drain");

    // W: PC wrap at 32'hFFFF_FFFC
    do_reset(0);
    pc_enable     = 1'b1;
    jump_register = 1'b1;
    rs_data       = 32'hFFFF_FFFC;
    exp_q.push_back(exp_word(32'hFFFF_FFFC));
    exp_q.push_back(exp_word(32'h0));
    step();
    jump_register = 1'b0;
    @(negedge clk);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("wrap_zero_addr", imem_addr, 32'h0);
    repeat (2) step();
    pc_enable = 1'b0;
    chk_drain("wrap_drain");

    // F: halt with an outstanding request; halt beats a redirect
    do_reset(2);
    pc_enable = 1'b1;
    halted    = 1'b1;
    jump      = 1'b1;
    jea       = 26'h3FF_FFFF;
    step();
    jump = 1'b0;
    @(negedge clk);
    chk("drain_req_c2", {31'd0, imem_req}, 32'd1);
    chk("drain_addr_c2", imem_addr, 32'h0);
    step();
    @(negedge clk);
    chk("drain_req_c3", {31'd0, imem_req}, 32'd1);
    step();
    halted = 1'b0;
    @(negedge clk);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_valid", {31'd0, inst_valid}, 32'd0);
    force_ready = 1'b1;
    jump        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      stall = i[0];
      @(negedge clk);
      chk("halt_sticky_req", {31'd0, imem_req}, 32'd0);
      chk("halt_sticky_valid", {31'd0, inst_valid}, 32'd0);
      chk("halt_sticky_inst", inst, 32'd0);
    end
    chk_drain("halt_drain");
    do_reset(0);
    @(negedge clk);
    chk("post_halt_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_halt_rst_addr", imem_addr, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
